// File: rtl/phase_scheduler.sv
// Demand-actuated four-phase intersection scheduler: latches requests, picks the
// next phase round-robin and sequences green / yellow / all-red with walk timing.
module phase_scheduler #(
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 60,
  parameter int YELLOW_TIME  = 4,
  parameter int ALL_RED_TIME = 2,
  parameter int PED_WALK     = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] car_req,
  input  logic [1:0] ped_req,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [1:0] walk,
  output logic [6:0] time_left,
  output logic [3:0] pending
);
  typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW} state_t;

  localparam logic [7:0] MIN_G   = 8'(MIN_GREEN);
  localparam logic [7:0] MIN_EFF = 8'((PED_WALK > MIN_GREEN) ? PED_WALK : MIN_GREEN);
  localparam logic [7:0] MAX_G   = 8'(MAX_GREEN);
  localparam logic [6:0] Y_T     = 7'(YELLOW_TIME);
  localparam logic [6:0] AR_T    = 7'(ALL_RED_TIME);
  localparam logic [6:0] PW      = 7'(PED_WALK);

  state_t     state, state_n;
  logic [1:0] cur, cur_n, nxt, nxt_n, pick;
  logic [6:0] cnt, cnt_n, g_elapsed, g_elapsed_n, walk_cnt, walk_cnt_n;
  logic       walk_granted, walk_granted_n, min_ok;
  logic [1:0] ped_lat, ped_lat_n, ped_set;
  logic [3:0] pending_n, set_req, others;
  logic [7:0] e;
  logic [3:0] green_n, yellow_n;
  logic [1:0] walk_n;
  logic [6:0] time_left_n;

  // Round-robin: nearest pending phase after cur wins.
  always_comb begin
    pick = cur;
    for (int k = 3; k >= 1; k--)
      if (pending[cur + 2'(k)]) pick = cur + 2'(k);
  end

  always_comb begin
    state_n        = state;
    cur_n          = cur;
    nxt_n          = nxt;
    cnt_n          = cnt;
    g_elapsed_n    = g_elapsed;
    walk_cnt_n     = walk_cnt;
    walk_granted_n = walk_granted;
    set_req        = car_req | {1'b0, ped_req[1], 1'b0, ped_req[0]};
    ped_set        = ped_req;
    if (state == GREEN) begin
      set_req[cur] = 1'b0;
      if (cur == 2'd0) ped_set[0] = 1'b0;
      if (cur == 2'd2) ped_set[1] = 1'b0;
    end
    pending_n = pending | set_req;
    ped_lat_n = ped_lat | ped_set;
    others    = pending & ~(4'b0001 << cur);
    e         = {1'b0, g_elapsed} + 8'd1;
    min_ok    = walk_granted ? (e >= MIN_EFF) : (e >= MIN_G);

    case (state)
      ALL_RED: if (tick) begin
        if (cnt == 7'd1) begin
          state_n          = GREEN;
          cur_n            = nxt;
          g_elapsed_n      = '0;
          pending_n[nxt]   = 1'b0;
          walk_cnt_n       = '0;
          walk_granted_n   = 1'b0;
          if ((nxt == 2'd0 && ped_lat[0]) || (nxt == 2'd2 && ped_lat[1])) begin
            ped_lat_n[nxt[1]] = 1'b0;
            walk_cnt_n        = PW;
            walk_granted_n    = 1'b1;
          end
        end else cnt_n = cnt - 7'd1;
      end
      GREEN: if (tick) begin
        if (e <= MAX_G) g_elapsed_n = e[6:0];
        if (walk_cnt != '0) walk_cnt_n = walk_cnt - 7'd1;
        if (others != '0 && ((min_ok && !car_req[cur]) || e >= MAX_G)) begin
          state_n    = YELLOW;
          nxt_n      = pick;
          cnt_n      = Y_T;
          walk_cnt_n = '0;
        end
      end
      YELLOW: if (tick) begin
        if (cnt == 7'd1) begin
          state_n = ALL_RED;
          cnt_n   = AR_T;
        end else cnt_n = cnt - 7'd1;
      end
      default: state_n = ALL_RED;
    endcase

    green_n     = (state_n == GREEN)  ? (4'b0001 << cur_n) : 4'b0000;
    yellow_n    = (state_n == YELLOW) ? (4'b0001 << cur_n) : 4'b0000;
    walk_n      = '0;
    time_left_n = '0;
    if (state_n == GREEN && walk_cnt_n != '0) begin
      walk_n[cur_n[1]] = 1'b1;
      time_left_n      = walk_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ALL_RED;
      cur          <= '0;
      nxt          <= '0;
      cnt          <= AR_T;
      g_elapsed    <= '0;
      walk_cnt     <= '0;
      walk_granted <= 1'b0;
      ped_lat      <= '0;
      pending      <= '0;
      green        <= '0;
      yellow       <= '0;
      walk         <= '0;
      time_left    <= '0;
    end else begin
      state        <= state_n;
      cur          <= cur_n;
      nxt          <= nxt_n;
      cnt          <= cnt_n;
      g_elapsed    <= g_elapsed_n;
      walk_cnt     <= walk_cnt_n;
      walk_granted <= walk_granted_n;
      ped_lat      <= ped_lat_n;
      pending      <= pending_n;
      green        <= green_n;
      yellow       <= yellow_n;
      walk         <= walk_n;
      time_left    <= time_left_n;
    end
  end
endmodule

// File: tb/tb_phase_scheduler.sv
// Directed scenario bench for phase_scheduler at default timing parameters.
module tb_phase_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] car_req = '0;
  logic [1:0] ped_req = '0;
  logic [3:0] green, yellow, pending;
  logic [1:0] walk;
  logic [6:0] time_left;
  logic [3:0] car_hold = '0;
  int checks = 0;
  int errors = 0;

  phase_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .car_req(car_req), .ped_req(ped_req),
    .green(green), .yellow(yellow), .walk(walk), .time_left(time_left), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; car_req = '0; ped_req = '0; car_hold = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick1;
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] c, input logic [1:0] p);
    @(negedge clk);
    car_req = car_hold | c; ped_req = p;
    @(negedge clk);
    car_req = car_hold; ped_req = '0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({green, yellow, walk, time_left, pending} !== 21'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {green, yellow, walk, time_left, pending});
    end
    tick1();
    checks++;
    if (green !== 4'b0000) begin errors++; $display("FAIL first_allred got %b want 0000", green); end
    tick1();
    checks++;
    if (green !== 4'b0001) begin errors++; $display("FAIL first_green got %b want 0001", green); end
    for (int i = 0; i < 100; i++) begin
      tick1();
      checks++;
      if ({green, yellow, pending} !== 12'b0001_0000_0000) begin
        errors++; $display("FAIL rest_p0 tick %0d got g=%b y=%b p=%b want g=0001 y=0000 p=0000", i, green, yellow, pending);
      end
    end
  endtask

  task automatic test_gap_out;
    do_reset();
    repeat (2) tick1();
    repeat (20) tick1();
    pulse(4'b0100, 2'b00);
    checks++;
    if (pending !== 4'b0100) begin errors++; $display("FAIL gap_pending got %b want 0100", pending); end
    for (int i = 0; i < 4; i++) begin
      tick1();
      checks++;
      if ({green, yellow} !== 8'b0000_0001) begin
        errors++; $display("FAIL gap_yellow tick %0d got g=%b y=%b want g=0000 y=0001", i, green, yellow);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick1();
      checks++;
      if ({green, yellow} !== 8'b0) begin errors++; $display("FAIL gap_allred tick %0d got g=%b y=%b want 0", i, green, yellow); end
    end
    tick1();
    checks++;
    if ({green, pending} !== 8'b0100_0000) begin
      errors++; $display("FAIL gap_green2 got g=%b p=%b want g=0100 p=0000", green, pending);
    end
  endtask

  task automatic test_max_out;
    do_reset();
    repeat (2) tick1();
    car_hold = 4'b0001; car_req = car_hold;
    pulse(4'b0010, 2'b00);
    for (int i = 1; i < 60; i++) begin
      tick1();
      checks++;
      if ({green, yellow} !== 8'b0001_0000) begin
        errors++; $display("FAIL maxout_green tick %0d got g=%b y=%b want g=0001 y=0000", i, green, yellow);
      end
    end
    tick1();
    checks++;
    if ({green, yellow} !== 8'b0000_0001) begin
      errors++; $display("FAIL maxout_yellow got g=%b y=%b want g=0000 y=0001", green, yellow);
    end
    car_hold = '0; car_req = '0;
  endtask

  task automatic test_round_robin;
    logic [3:0] order [4];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000;
    do_reset();
    repeat (2) tick1();
    pulse(4'b1000, 2'b00);
    pulse(4'b0010, 2'b00);
    pulse(4'b0100, 2'b00);
    checks++;
    if (pending !== 4'b1110) begin errors++; $display("FAIL rr_pending got %b want 1110", pending); end
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 1; i < 10; i++) begin
        tick1();
        checks++;
        if (green !== order[ph]) begin errors++; $display("FAIL rr_green ph %0d tick %0d got %b want %b", ph, i, green, order[ph]); end
      end
      tick1();
      checks++;
      if (yellow !== order[ph]) begin errors++; $display("FAIL rr_yellow ph %0d got %b want %b", ph, yellow, order[ph]); end
      repeat (6) tick1();
      checks++;
      if (green !== order[ph+1]) begin errors++; $display("FAIL rr_next ph %0d got %b want %b", ph, green, order[ph+1]); end
    end
    repeat (30) tick1();
    checks++;
    if ({green, yellow, pending} !== 12'b1000_0000_0000) begin
      errors++; $display("FAIL rr_rest_p3 got g=%b y=%b p=%b want g=1000 y=0000 p=0000", green, yellow, pending);
    end
  endtask

  task automatic test_ped_walk;
    do_reset();
    repeat (2) tick1();
    pulse(4'b1000, 2'b10);
    checks++;
    if (pending !== 4'b1100) begin errors++; $display("FAIL ped_pending got %b want 1100", pending); end
    repeat (10) tick1();
    repeat (6) tick1();
    checks++;
    if ({green, walk, time_left} !== {4'b0100, 2'b10, 7'd15}) begin
      errors++; $display("FAIL ped_start got g=%b w=%b t=%0d want g=0100 w=10 t=15", green, walk, time_left);
    end
    for (int k = 1; k < 15; k++) begin
      tick1();
      checks++;
      if ({green, walk, time_left} !== {4'b0100, 2'b10, 7'(15 - k)}) begin
        errors++; $display("FAIL ped_count tick %0d got g=%b w=%b t=%0d want g=0100 w=10 t=%0d", k, green, walk, time_left, 15 - k);
      end
    end
    tick1();
    checks++;
    if ({green, yellow, walk, time_left} !== {4'b0000, 4'b0100, 2'b00, 7'd0}) begin
      errors++; $display("FAIL ped_end got g=%b y=%b w=%b t=%0d want g=0000 y=0100 w=00 t=0", green, yellow, walk, time_left);
    end
  endtask

  task automatic test_reset_mid_yellow;
    do_reset();
    repeat (2) tick1();
    pulse(4'b0100, 2'b00);
    repeat (16) tick1();
    checks++;
    if (green !== 4'b0100) begin errors++; $display("FAIL rmy_setup got %b want 0100", green); end
    pulse(4'b1010, 2'b00);
    repeat (10) tick1();
    repeat (2) tick1();
    checks++;
    if ({yellow, pending} !== 8'b0100_1010) begin
      errors++; $display("FAIL rmy_yellow got y=%b p=%b want y=0100 p=1010", yellow, pending);
    end
    @(negedge clk);
    rst = 1'b1; tick = 1'b1;
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;
    checks++;
    if ({green, yellow, walk, time_left, pending} !== 21'd0) begin
      errors++; $display("FAIL rmy_cleared got %h want 0", {green, yellow, walk, time_left, pending});
    end
    tick1();
    checks++;
    if (green !== 4'b0000) begin errors++; $display("FAIL rmy_allred got %b want 0000", green); end
    tick1();
    checks++;
    if ({green, pending} !== 8'b0001_0000) begin
      errors++; $display("FAIL rmy_restart got g=%b p=%b want g=0001 p=0000", green, pending);
    end
  endtask

  initial begin
    test_reset();
    test_gap_out();
    test_max_out();
    test_round_robin();
    test_ped_walk();
    test_reset_mid_yellow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
